// File: rtl/mem_wb_stage_buf.sv
// MEM->WB pipeline stage with valid/ready handshake, 1-entry skid buffer, flush and lane sanitising.
// Optional macro MWB_STALL_CNT_EN adds a saturating 16-bit stall counter output.
module mem_wb_stage_buf #(
    parameter int LANES = 2,
    parameter int DW    = 16,
    parameter int RW    = 3,
    parameter int CW    = 3
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  in_push,
    output logic                  in_ready,
    input  logic [LANES-1:0]      in_lane_valid,
    input  logic [LANES*DW-1:0]   in_pc_plus2,
    input  logic [LANES*CW-1:0]   in_wb_ctl,
    input  logic [LANES*DW-1:0]   in_alu,
    input  logic [LANES*DW-1:0]   in_mem_rdata,
    input  logic [LANES*DW-1:0]   in_zero_pad,
    input  logic [LANES*RW-1:0]   in_dest,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [LANES-1:0]      out_lane_valid,
    output logic [LANES*DW-1:0]   out_pc_plus2,
    output logic [LANES*CW-1:0]   out_wb_ctl,
    output logic [LANES*DW-1:0]   out_alu,
    output logic [LANES*DW-1:0]   out_mem_rdata,
    output logic [LANES*DW-1:0]   out_zero_pad,
    output logic [LANES*RW-1:0]   out_dest
`ifdef MWB_STALL_CNT_EN
    ,
    output logic [15:0]           stall_cnt
`endif
);

    localparam int GW = LANES + 4 * LANES * DW + LANES * CW + LANES * RW;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } state_t;

    state_t              state_r;
    state_t              state_nxt_s;
    logic                in_ready_r;
    logic                out_valid_r;
    logic [GW-1:0]       main_r;
    logic [GW-1:0]       skid_r;
    logic [GW-1:0]       in_group_s;
    logic                accept_s;
    logic                consume_s;
    logic                load_main_s;
    logic                load_skid_s;
    logic                skid_to_main_s;
    logic [LANES*DW-1:0] pc_s;
    logic [LANES*CW-1:0] ctl_s;
    logic [LANES*DW-1:0] alu_s;
    logic [LANES*DW-1:0] mem_s;
    logic [LANES*DW-1:0] zp_s;
    logic [LANES*RW-1:0] dest_s;

    assign accept_s  = in_push & in_ready_r;
    assign consume_s = out_valid_r & out_ready;

    // Zero every field of lanes that arrive invalid so no stale control reaches WB.
    always_comb begin
        pc_s   = {(LANES*DW){1'b0}};
        ctl_s  = {(LANES*CW){1'b0}};
        alu_s  = {(LANES*DW){1'b0}};
        mem_s  = {(LANES*DW){1'b0}};
        zp_s   = {(LANES*DW){1'b0}};
        dest_s = {(LANES*RW){1'b0}};
        for (int i = 0; i < LANES; i++) begin
            if (in_lane_valid[i]) begin
                pc_s[i*DW +: DW]   = in_pc_plus2[i*DW +: DW];
                ctl_s[i*CW +: CW]  = in_wb_ctl[i*CW +: CW];
                alu_s[i*DW +: DW]  = in_alu[i*DW +: DW];
                mem_s[i*DW +: DW]  = in_mem_rdata[i*DW +: DW];
                zp_s[i*DW +: DW]   = in_zero_pad[i*DW +: DW];
                dest_s[i*RW +: RW] = in_dest[i*RW +: RW];
            end else begin
                pc_s[i*DW +: DW]   = {DW{1'b0}};
                ctl_s[i*CW +: CW]  = {CW{1'b0}};
                alu_s[i*DW +: DW]  = {DW{1'b0}};
                mem_s[i*DW +: DW]  = {DW{1'b0}};
                zp_s[i*DW +: DW]   = {DW{1'b0}};
                dest_s[i*RW +: RW] = {RW{1'b0}};
            end
        end
    end

    assign in_group_s = {in_lane_valid, pc_s, ctl_s, alu_s, mem_s, zp_s, dest_s};

    // Next-state and storage-steering decode for the skid FSM.
    always_comb begin
        state_nxt_s    = state_r;
        load_main_s    = 1'b0;
        load_skid_s    = 1'b0;
        skid_to_main_s = 1'b0;
        case (state_r)
            EMPTY: begin
                if (accept_s) begin
                    state_nxt_s = FULL;
                    load_main_s = 1'b1;
                end else begin
                    state_nxt_s = EMPTY;
                end
            end
            FULL: begin
                if (accept_s && consume_s) begin
                    state_nxt_s = FULL;
                    load_main_s = 1'b1;
                end else if (accept_s) begin
                    state_nxt_s = SKID;
                    load_skid_s = 1'b1;
                end else if (consume_s) begin
                    state_nxt_s = EMPTY;
                end else begin
                    state_nxt_s = FULL;
                end
            end
            SKID: begin
                if (consume_s) begin
                    state_nxt_s    = FULL;
                    skid_to_main_s = 1'b1;
                end else begin
                    state_nxt_s = SKID;
                end
            end
            default: begin
                state_nxt_s = EMPTY;
            end
        endcase
    end

    // State, handshake flags and payload registers; reset beats flush beats normal flow.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_r     <= EMPTY;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            main_r      <= {GW{1'b0}};
            skid_r      <= {GW{1'b0}};
        end else if (flush) begin
            state_r                  <= EMPTY;
            in_ready_r               <= 1'b1;
            out_valid_r              <= 1'b0;
            main_r[GW-1 -: LANES]    <= {LANES{1'b0}};
            skid_r[GW-1 -: LANES]    <= {LANES{1'b0}};
        end else begin
            state_r     <= state_nxt_s;
            in_ready_r  <= (state_nxt_s != SKID);
            out_valid_r <= (state_nxt_s != EMPTY);
            if (load_main_s) begin
                main_r <= in_group_s;
            end else if (skid_to_main_s) begin
                main_r <= skid_r;
            end
            if (load_skid_s) begin
                skid_r <= in_group_s;
            end
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign {out_lane_valid, out_pc_plus2, out_wb_ctl, out_alu,
            out_mem_rdata, out_zero_pad, out_dest} = main_r;

`ifdef MWB_STALL_CNT_EN
    logic [15:0] stall_cnt_r;

    // Saturating count of cycles where a held group is refused by WB; flush leaves it alone.
    always_ff @(posedge clock) begin
        if (!reset) begin
            stall_cnt_r <= 16'h0000;
        end else if (out_valid_r && !out_ready && (stall_cnt_r != 16'hFFFF)) begin
            stall_cnt_r <= stall_cnt_r + 16'h0001;
        end
    end

    assign stall_cnt = stall_cnt_r;
`endif

endmodule

// File: tb/tb_mem_wb_stage_buf.sv
// Directed self-checking bench for mem_wb_stage_buf (LANES=2, DW=16, RW=3, CW=3).
module tb_mem_wb_stage_buf;

    logic        clock;
    logic        reset;
    logic        flush;
    logic        in_push;
    logic        in_ready;
    logic [1:0]  in_lane_valid;
    logic [31:0] in_pc_plus2;
    logic [5:0]  in_wb_ctl;
    logic [31:0] in_alu;
    logic [31:0] in_mem_rdata;
    logic [31:0] in_zero_pad;
    logic [5:0]  in_dest;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  out_lane_valid;
    logic [31:0] out_pc_plus2;
    logic [5:0]  out_wb_ctl;
    logic [31:0] out_alu;
    logic [31:0] out_mem_rdata;
    logic [31:0] out_zero_pad;
    logic [5:0]  out_dest;
`ifdef MWB_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    int tests;
    int failed;

    mem_wb_stage_buf #(.LANES(2), .DW(16), .RW(3), .CW(3)) dut (
        .clock         (clock),
        .reset         (reset),
        .flush         (flush),
        .in_push       (in_push),
        .in_ready      (in_ready),
        .in_lane_valid (in_lane_valid),
        .in_pc_plus2   (in_pc_plus2),
        .in_wb_ctl     (in_wb_ctl),
        .in_alu        (in_alu),
        .in_mem_rdata  (in_mem_rdata),
        .in_zero_pad   (in_zero_pad),
        .in_dest       (in_dest),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_lane_valid(out_lane_valid),
        .out_pc_plus2  (out_pc_plus2),
        .out_wb_ctl    (out_wb_ctl),
        .out_alu       (out_alu),
        .out_mem_rdata (out_mem_rdata),
        .out_zero_pad  (out_zero_pad),
        .out_dest      (out_dest)
`ifdef MWB_STALL_CNT_EN
        ,
        .stall_cnt     (stall_cnt)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: capture on posedge, return at negedge for sampling and driving.
    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    // Drive a group whose lane1 pc_plus2 is v; other fields derived from v.
    task automatic load(input logic [1:0] lv, input logic [15:0] v);
        in_push       = 1'b1;
        in_lane_valid = lv;
        in_pc_plus2   = {v, v + 16'h0100};
        in_alu        = {v ^ 16'h5555, v};
        in_mem_rdata  = {~v, v};
        in_zero_pad   = {v, ~v};
        in_wb_ctl     = {3'b011, 3'b110};
        in_dest       = {3'd5, 3'd2};
    endtask

    initial begin
        tests = 0;
        failed = 0;
        reset = 1'b0;
        flush = 1'b0;
        in_push = 1'b0;
        out_ready = 1'b0;
        load(2'b11, 16'h0000);
        in_push = 1'b0;
        @(negedge clock);
        tick();
        tick();
        reset = 1'b1;
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_pc", out_pc_plus2, 32'd0);
        chk("rst_lv", {30'd0, out_lane_valid}, 32'd0);

        // Streaming, out_ready high
        out_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            load(2'b11, 16'(2 * k));
            tick();
            chk("stream_valid", {31'd0, out_valid}, 32'd1);
            chk("stream_pc1", {16'd0, out_pc_plus2[31:16]}, 32'(2 * k));
            chk("stream_ready", {31'd0, in_ready}, 32'd1);
        end
        chk("stream_dest", {26'd0, out_dest}, {26'd0, 3'd5, 3'd2});
        chk("stream_zp", out_zero_pad, {16'h0008, 16'hFFF7});
        in_push = 1'b0;
        tick();
        chk("stream_drain", {31'd0, out_valid}, 32'd0);

        // Back-pressure into the skid register
        out_ready = 1'b0;
        load(2'b11, 16'h00A0);
        tick();
        chk("bp_a_ready", {31'd0, in_ready}, 32'd1);
        load(2'b11, 16'h00B0);
        tick();
        chk("bp_skid_ready", {31'd0, in_ready}, 32'd0);
        chk("bp_hold_a", {16'd0, out_pc_plus2[31:16]}, 32'h00A0);
        in_push = 1'b0;
        tick();
        chk("bp_still_a", {16'd0, out_pc_plus2[31:16]}, 32'h00A0);
        out_ready = 1'b1;
        tick();
        chk("bp_b", {16'd0, out_pc_plus2[31:16]}, 32'h00B0);
        chk("bp_b_alu1", {16'd0, out_alu[31:16]}, {16'd0, 16'h00B0 ^ 16'h5555});
        chk("bp_ready_back", {31'd0, in_ready}, 32'd1);
        tick();
        chk("bp_empty", {31'd0, out_valid}, 32'd0);

        // Lane sanitise
        out_ready = 1'b0;
        load(2'b01, 16'h0042);
        in_alu    = {16'hBEEF, 16'h1234};
        in_wb_ctl = {3'b111, 3'b101};
        tick();
        chk("san_lv", {30'd0, out_lane_valid}, 32'h1);
        chk("san_alu1", {16'd0, out_alu[31:16]}, 32'd0);
        chk("san_ctl1", {29'd0, out_wb_ctl[5:3]}, 32'd0);
        chk("san_pc1", {16'd0, out_pc_plus2[31:16]}, 32'd0);
        chk("san_alu0", {16'd0, out_alu[15:0]}, 32'h1234);
        chk("san_ctl0", {29'd0, out_wb_ctl[2:0]}, 32'h5);
        in_push = 1'b0;
        out_ready = 1'b1;
        tick();

        // All-invalid group still occupies a slot
        out_ready = 1'b0;
        load(2'b00, 16'h0077);
        tick();
        chk("nolane_valid", {31'd0, out_valid}, 32'd1);
        chk("nolane_pc", out_pc_plus2, 32'd0);
        in_push = 1'b0;
        out_ready = 1'b1;
        tick();

        // Flush while FULL with an accepted group in the same cycle
        out_ready = 1'b0;
        load(2'b11, 16'h0060);
        tick();
        load(2'b11, 16'h0061);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        in_push = 1'b0;
        chk("flf_valid", {31'd0, out_valid}, 32'd0);
        chk("flf_lv", {30'd0, out_lane_valid}, 32'd0);
        out_ready = 1'b1;
        tick();
        chk("flf_discard", {31'd0, out_valid}, 32'd0);

        // Flush in SKID with a simultaneous push
        out_ready = 1'b0;
        load(2'b11, 16'h00C0);
        tick();
        load(2'b11, 16'h00D0);
        tick();
        chk("fls_skid", {31'd0, in_ready}, 32'd0);
        load(2'b11, 16'h00E0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        in_push = 1'b0;
        chk("fls_valid", {31'd0, out_valid}, 32'd0);
        chk("fls_ready", {31'd0, in_ready}, 32'd1);
        chk("fls_lv", {30'd0, out_lane_valid}, 32'd0);
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("fls_gone", {31'd0, out_valid}, 32'd0);
        end
        load(2'b11, 16'h00F0);
        tick();
        in_push = 1'b0;
        chk("fls_next", {16'd0, out_pc_plus2[31:16]}, 32'h00F0);
        tick();
        chk("fls_next_only", {31'd0, out_valid}, 32'd0);

        // Reset asserted mid-stall in SKID
        out_ready = 1'b0;
        load(2'b11, 16'h0011);
        tick();
        load(2'b11, 16'h0022);
        tick();
        chk("rs_skid", {31'd0, in_ready}, 32'd0);
        in_push = 1'b0;
        reset = 1'b0;
        tick();
        reset = 1'b1;
        chk("rs_valid", {31'd0, out_valid}, 32'd0);
        chk("rs_ready", {31'd0, in_ready}, 32'd1);
        chk("rs_pc", out_pc_plus2, 32'd0);
        chk("rs_alu", out_alu, 32'd0);
        chk("rs_mem", out_mem_rdata, 32'd0);
        chk("rs_ctl", {26'd0, out_wb_ctl}, 32'd0);
        out_ready = 1'b1;
        load(2'b11, 16'h007E);
        tick();
        in_push = 1'b0;
        chk("rs_push_valid", {31'd0, out_valid}, 32'd1);
        chk("rs_push_pc", {16'd0, out_pc_plus2[31:16]}, 32'h007E);
        tick();
        chk("rs_no_stale", {31'd0, out_valid}, 32'd0);

`ifdef MWB_STALL_CNT_EN
        // Stall counter: 5 refused cycles, flush keeps it, reset clears it
        reset = 1'b0;
        tick();
        reset = 1'b1;
        chk("sc_rst", {16'd0, stall_cnt}, 32'd0);
        out_ready = 1'b0;
        load(2'b11, 16'h0033);
        tick();
        in_push = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        chk("sc_five", {16'd0, stall_cnt}, 32'd5);
        out_ready = 1'b1;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("sc_flush", {16'd0, stall_cnt}, 32'd5);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        chk("sc_clear", {16'd0, stall_cnt}, 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
